dmem_arbiter: RTL and testbench

DMEM_ARBITER -- requirements
Module: dmem_arbiter

---
 rtl/dmem_arbiter_if.sv | 35 +++
 rtl/dmem_arbiter.sv | 138 +++++++++++++
 tb/tb_dmem_arbiter.sv | 247 ++++++++++++++++++++++++
 3 files changed

// File: rtl/dmem_arbiter_if.sv
// dmem_arbiter_if: two-port request/response bundle for the data-memory arbiter.
// master = requester side (core LSU / debug-DMA), slave = arbiter side.
interface dmem_arbiter_if;
  logic        p0_req;
  logic        p0_we;
  logic [31:0] p0_addr;
  logic [31:0] p0_wdata;
  logic        p0_gnt;
  logic        p0_rvalid;
  logic [31:0] p0_rdata;
  logic        p0_err;

  logic        p1_req;
  logic        p1_we;
  logic [31:0] p1_addr;
  logic [31:0] p1_wdata;
  logic        p1_gnt;
  logic        p1_rvalid;
  logic [31:0] p1_rdata;
  logic        p1_err;

  modport master (
    output p0_req, p0_we, p0_addr, p0_wdata,
    output p1_req, p1_we, p1_addr, p1_wdata,
    input  p0_gnt, p0_rvalid, p0_rdata, p0_err,
    input  p1_gnt, p1_rvalid, p1_rdata, p1_err
  );

  modport slave (
    input  p0_req, p0_we, p0_addr, p0_wdata,
    input  p1_req, p1_we, p1_addr, p1_wdata,
    output p0_gnt, p0_rvalid, p0_rdata, p0_err,
    output p1_gnt, p1_rvalid, p1_rdata, p1_err
  );
endinterface

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: two-port arbiter in front of a single-ported data memory.
// Fixed 3-cycle transaction: IDLE (grant) -> MEM (strobe) -> RESP (rvalid).
// Simultaneous requests are round-robin by default; define
// DMEM_ARB_FIXED_PRIORITY_EN to make port 0 always win and drop the pointer.
module dmem_arbiter #(
  parameter int unsigned ADDR_WORDS = 64
) (
  input  logic            clk,
  input  logic            reset,
  dmem_arbiter_if.slave   bus,
  output logic            MemWrite,
  output logic            MemRread,
  output logic [31:0]     read_address,
  output logic [31:0]     write_data,
  input  logic [31:0]     MemData_out
);

  typedef enum logic [1:0] {IDLE, MEM, RESP} state_e;

  state_e      state_q, state_d;
  logic        gnt0, gnt1, accept;
  logic        we_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic        port_q;
  logic [31:0] rdata_q;
  logic        err_q;
  logic        in_range;

`ifndef DMEM_ARB_FIXED_PRIORITY_EN
  // prio_q = 1 means port 1 wins the next tie (port 0 was granted last)
  logic        prio_q;
`endif

  assign in_range = (addr_q < 32'(ADDR_WORDS));
  assign accept   = gnt0 | gnt1;

  // Grant selection: only in IDLE, lone requests win outright, ties arbitrated
  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (!reset && state_q == IDLE) begin
      if (bus.p0_req && bus.p1_req) begin
`ifdef DMEM_ARB_FIXED_PRIORITY_EN
        gnt0 = 1'b1;
`else
        gnt0 = !prio_q;
        gnt1 = prio_q;
`endif
      end else begin
        gnt0 = bus.p0_req;
        gnt1 = bus.p1_req;
      end
    end
  end

  // State register
  always_ff @(posedge clk) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (accept) state_d = MEM;
      MEM:     state_d = RESP;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Transaction latch, response capture and priority pointer
  always_ff @(posedge clk) begin
    if (reset) begin
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      port_q  <= 1'b0;
      rdata_q <= '0;
      err_q   <= 1'b0;
`ifndef DMEM_ARB_FIXED_PRIORITY_EN
      prio_q  <= 1'b0;
`endif
    end else begin
      if (accept) begin
        we_q    <= gnt1 ? bus.p1_we    : bus.p0_we;
        addr_q  <= gnt1 ? bus.p1_addr  : bus.p0_addr;
        wdata_q <= gnt1 ? bus.p1_wdata : bus.p0_wdata;
        port_q  <= gnt1;
`ifndef DMEM_ARB_FIXED_PRIORITY_EN
        prio_q  <= gnt0;
`endif
      end
      if (state_q == MEM) begin
        rdata_q <= (!we_q && in_range) ? MemData_out : '0;
        err_q   <= !in_range;
      end
    end
  end

  // Outputs: grants, memory strobes in MEM, response pulse in RESP; all quiet in reset
  always_comb begin
    bus.p0_gnt    = gnt0;
    bus.p1_gnt    = gnt1;
    MemWrite      = 1'b0;
    MemRread      = 1'b0;
    read_address  = '0;
    write_data    = '0;
    bus.p0_rvalid = 1'b0;
    bus.p1_rvalid = 1'b0;
    bus.p0_rdata  = '0;
    bus.p1_rdata  = '0;
    bus.p0_err    = 1'b0;
    bus.p1_err    = 1'b0;
    if (!reset) begin
      if (state_q == MEM) begin
        read_address = addr_q;
        write_data   = wdata_q;
        MemWrite     = we_q && in_range;
        MemRread     = !we_q && in_range;
      end
      if (state_q == RESP) begin
        if (port_q) begin
          bus.p1_rvalid = 1'b1;
          bus.p1_rdata  = rdata_q;
          bus.p1_err    = err_q;
        end else begin
          bus.p0_rvalid = 1'b1;
          bus.p0_rdata  = rdata_q;
          bus.p0_err    = err_q;
        end
      end
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: scoreboard bench for dmem_arbiter with a 64-word memory model.
module tb_dmem_arbiter;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        MemWrite, MemRread;
  logic [31:0] read_address, write_data, MemData_out;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  dmem_arbiter_if bus ();

  dmem_arbiter #(.ADDR_WORDS(64)) dut (
    .clk          (clk),
    .reset        (reset),
    .bus          (bus),
    .MemWrite     (MemWrite),
    .MemRread     (MemRread),
    .read_address (read_address),
    .write_data   (write_data),
    .MemData_out  (MemData_out)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Attached memory: combinational read, write on clock edge
  logic [31:0] mem    [64];
  logic [31:0] refmem [64];
  assign MemData_out = (read_address < 32'd64) ? mem[read_address[5:0]] : 32'h0BAD_0BAD;
  always @(posedge clk) if (MemWrite && read_address < 32'd64) mem[read_address[5:0]] <= write_data;

  typedef struct { bit port; logic [31:0] rdata; bit err; int cyc; } resp_t;
  typedef struct { int cyc; bit we; bit inr; logic [31:0] addr; logic [31:0] wdata; } strb_t;
  typedef struct { bit port; int cyc; } gnt_t;

  resp_t resp_q [$];
  strb_t strb_q [$];
  gnt_t  gnt_log [$];
  bit    last_gnt = 1'b1;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Monitor: push expectations on grant, compare strobes and responses as they appear
  always @(negedge clk) begin
    bit          g_port, g_we, inr, exp_win;
    logic [31:0] g_a, g_wd, rd;
    resp_t       r;
    strb_t       s;
    if (reset) begin
      check("reset_quiet", 64'({bus.p0_gnt, bus.p1_gnt, bus.p0_rvalid, bus.p1_rvalid,
                               bus.p0_err, bus.p1_err, MemWrite, MemRread}), 64'd0);
      resp_q.delete();
      strb_q.delete();
      last_gnt = 1'b1;
    end else begin
      check("gnt_onehot", 64'(bus.p0_gnt & bus.p1_gnt), 64'd0);
      if (bus.p0_gnt || bus.p1_gnt) begin
        g_port = bus.p1_gnt;
        if (bus.p0_req && bus.p1_req) begin
`ifdef DMEM_ARB_FIXED_PRIORITY_EN
          exp_win = 1'b0;
`else
          exp_win = ~last_gnt;
`endif
          check("rr_winner", 64'(g_port), 64'(exp_win));
        end
        last_gnt = g_port;
        gnt_log.push_back('{g_port, cyc});
        g_we = g_port ? bus.p1_we    : bus.p0_we;
        g_a  = g_port ? bus.p1_addr  : bus.p0_addr;
        g_wd = g_port ? bus.p1_wdata : bus.p0_wdata;
        inr  = (g_a < 32'd64);
        strb_q.push_back('{cyc + 1, g_we, inr, g_a, g_wd});
        if (!inr) rd = '0;
        else if (g_we) begin refmem[g_a[5:0]] = g_wd; rd = '0; end
        else rd = refmem[g_a[5:0]];
        resp_q.push_back('{g_port, rd, !inr, cyc + 2});
      end
      if (strb_q.size() != 0 && strb_q[0].cyc == cyc) begin
        s = strb_q.pop_front();
        check("mem_write", 64'(MemWrite), 64'(s.we & s.inr));
        check("mem_read",  64'(MemRread), 64'(!s.we & s.inr));
        check("mem_addr",  64'(read_address), 64'(s.addr));
        check("mem_wdata", 64'(write_data), 64'(s.wdata));
      end else begin
        check("bus_idle_strb", 64'({MemWrite, MemRread}), 64'd0);
        check("bus_idle_data", {read_address, write_data}, 64'd0);
      end
      if (bus.p0_rvalid || bus.p1_rvalid) begin
        if (resp_q.size() == 0) check("rvalid_unexpected", 64'd1, 64'd0);
        else begin
          r = resp_q.pop_front();
          check("rsp_port",  64'({bus.p0_rvalid, bus.p1_rvalid}), r.port ? 64'd1 : 64'd2);
          check("rsp_cycle", 64'(cyc), 64'(r.cyc));
          check("rsp_rdata", 64'(r.port ? bus.p1_rdata : bus.p0_rdata), 64'(r.rdata));
          check("rsp_err",   64'(r.port ? bus.p1_err : bus.p0_err), 64'(r.err));
        end
      end else if (resp_q.size() != 0 && resp_q[0].cyc <= cyc) begin
        check("rvalid_missing", 64'd0, 64'd1);
        void'(resp_q.pop_front());
      end
      if (!bus.p0_rvalid) check("p0_idle_out", 64'({bus.p0_err, bus.p0_rdata}), 64'd0);
      if (!bus.p1_rvalid) check("p1_idle_out", 64'({bus.p1_err, bus.p1_rdata}), 64'd0);
    end
  end

  task automatic drive(input bit port, input bit req, input bit we, input logic [31:0] a, input logic [31:0] wd);
    if (port) begin
      bus.p1_req = req; bus.p1_we = we; bus.p1_addr = a; bus.p1_wdata = wd;
    end else begin
      bus.p0_req = req; bus.p0_we = we; bus.p0_addr = a; bus.p0_wdata = wd;
    end
  endtask

  task automatic wait_gnts(input int n);
    for (int i = 0; i < 40 && gnt_log.size() < n; i++) begin
      @(negedge clk); #1;
    end
    if (gnt_log.size() < n) check("gnt_timeout", 64'(gnt_log.size()), 64'(n));
  endtask

  task automatic issue(input bit port, input bit we, input logic [31:0] a, input logic [31:0] wd);
    gnt_log.delete();
    @(posedge clk); #1;
    drive(port, 1'b1, we, a, wd);
    wait_gnts(1);
    @(posedge clk); #1;
    drive(port, 1'b0, 1'b0, '0, '0);
    repeat (2) @(posedge clk);
  endtask

  task automatic pulse_reset();
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 64; i++) begin
      mem[i]    = 32'hA5A5_0000 ^ (i * 32'h0101_0101);
      refmem[i] = 32'hA5A5_0000 ^ (i * 32'h0101_0101);
    end
    drive(1'b0, 1'b0, 1'b0, '0, '0);
    drive(1'b1, 1'b0, 1'b0, '0, '0);
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;

    // Write then read back on port 0
    issue(1'b0, 1'b1, 32'd5, 32'hDEAD_BEEF);
    issue(1'b0, 1'b0, 32'd5, 32'h0);

    // Mixed traffic on both ports including edge addresses
    for (int i = 0; i < 10; i++) begin
      logic [31:0] a;
      if (i == 0)      a = 32'd63;
      else if (i == 1) a = 32'hFFFF_FFFF;
      else             a = 32'($urandom_range(0, 59));
      issue(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), a, $urandom);
    end
    issue(1'b1, 1'b0, 32'd63, 32'h0);

    // Out-of-range read on port 1
    issue(1'b1, 1'b0, 32'd64, 32'h0);

    // Both ports requesting continuously from a fresh reset
    pulse_reset();
    gnt_log.delete();
    drive(1'b0, 1'b1, 1'b0, 32'd10, 32'h0);
    drive(1'b1, 1'b1, 1'b0, 32'd20, 32'h0);
    wait_gnts(4);
    @(posedge clk); #1;
    drive(1'b0, 1'b0, 1'b0, '0, '0);
    drive(1'b1, 1'b0, 1'b0, '0, '0);
    check("pair_count", 64'(gnt_log.size()), 64'd4);
    for (int i = 0; i < 4 && i < gnt_log.size(); i++) begin
`ifdef DMEM_ARB_FIXED_PRIORITY_EN
      check("pair_order", 64'(gnt_log[i].port), 64'd0);
`else
      check("pair_order", 64'(gnt_log[i].port), 64'(i % 2));
`endif
      if (i > 0) check("pair_spacing", 64'(gnt_log[i].cyc - gnt_log[i-1].cyc), 64'd3);
    end
    repeat (3) @(posedge clk);

    // Reset during MEM of a port-0 write aborts it
    gnt_log.delete();
    @(posedge clk); #1;
    drive(1'b0, 1'b1, 1'b1, 32'd60, 32'h1234_5678);
    wait_gnts(1);
    @(posedge clk); #1;
    drive(1'b0, 1'b0, 1'b0, '0, '0);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    gnt_log.delete();
    drive(1'b0, 1'b1, 1'b0, 32'd11, 32'h0);
    drive(1'b1, 1'b1, 1'b0, 32'd12, 32'h0);
    wait_gnts(1);
    @(posedge clk); #1;
    drive(1'b0, 1'b0, 1'b0, '0, '0);
    drive(1'b1, 1'b0, 1'b0, '0, '0);
    if (gnt_log.size() > 0) check("post_reset_winner", 64'(gnt_log[0].port), 64'd0);
    repeat (3) @(posedge clk);

    // Inputs change right after grant; req held so the next grant comes 3 cycles later
    gnt_log.delete();
    @(posedge clk); #1;
    drive(1'b0, 1'b1, 1'b1, 32'd7, 32'hCAFE_0007);
    wait_gnts(1);
    @(posedge clk); #1;
    drive(1'b0, 1'b1, 1'b1, 32'd9, 32'hCAFE_0009);
    wait_gnts(2);
    @(posedge clk); #1;
    drive(1'b0, 1'b0, 1'b0, '0, '0);
    if (gnt_log.size() > 1) check("hold_spacing", 64'(gnt_log[1].cyc - gnt_log[0].cyc), 64'd3);
    repeat (3) @(posedge clk);
    issue(1'b0, 1'b0, 32'd7, 32'h0);
    issue(1'b1, 1'b0, 32'd9, 32'h0);

    repeat (5) @(posedge clk);
    #1;
    check("resp_drained",  64'(resp_q.size()), 64'd0);
    check("strb_drained",  64'(strb_q.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
